button_debounce: RTL
====================

Name: button_debounce

Overview:
- Conditions a raw Basys 3 push-button or switch input before it drives the d input of the team's d_ff_reset and other registered logic.
- Synchronises the asynchronous pin into the clk domain with two flops.
- Filters contact bounce with a stability counter and FSM.
- Outputs a clean level plus single-cycle press and release strobes.

Parameters:
- STABLE_COUNT, 1000000, consecutive clk cycles the synchronised input must hold a new value before it is accepted (10 ms at 100 MHz). Legal range 2 .. 2^CNT_WIDTH-1. Out-of-range values are a elaboration-time error ($error/assertion).
- CNT_WIDTH, 20, width of the stability counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising clk edge
- btn_in  input  1  raw, asynchronous, bouncing button/switch pin
- btn_level  output  1  debounced level, registered
- btn_press  output  1  one-cycle strobe on accepted 0->1 transition, registered
- btn_release  output  1  one-cycle strobe on accepted 1->0 transition, registered

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). No asynchronous clear anywhere.
- Reset values: sync0=0, sync1=0, count=0, state=IDLE_LOW, btn_level=0, btn_press=0, btn_release=0. These apply after the first clk edge with reset=1, independent of btn_in.
- Reset dominates every other transition on the same edge, including a strobe that would otherwise fire.
- Synchroniser: sync0<=btn_in, sync1<=sync0. Only sync1 is used by the FSM; btn_in never reaches other logic.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
- IDLE_LOW:
  - sync1=1 -> WAIT_HIGH, count<=1.
  - Else stay, count<=0.
- WAIT_HIGH:
  - sync1=0 -> IDLE_LOW, count<=0 (bounce rejected, no strobe).
  - sync1=1 and count==STABLE_COUNT-1 -> IDLE_HIGH, count<=0, btn_level<=1, btn_press<=1.
  - Else count<=count+1.
- IDLE_HIGH / WAIT_LOW: mirror of the above with polarity inverted. Acceptance sets btn_level<=0, btn_release<=1.
- Strobes:
  - Default 0 every cycle; high for exactly one cycle, coincident with the cycle btn_level first shows the new value.
  - btn_press and btn_release are never high in the same cycle.
- Latency: btn_in changes before edge k and stays stable. btn_level updates at edge k+1+STABLE_COUNT (STABLE_COUNT+2 edges after the change). Example: 6 edges for STABLE_COUNT=4.
- Bounce rule: any opposite-value sync1 sample during a WAIT state aborts the WAIT. A subsequent change needs a full fresh STABLE_COUNT run.
- Counter: never exceeds STABLE_COUNT-1, never wraps. Width rule: count compared at CNT_WIDTH bits.
- Reset mid-WAIT: the partial count is discarded. If btn_in is held high through reset release, the block re-qualifies from IDLE_LOW: btn_level rises STABLE_COUNT+2 edges after the first edge with reset=0, with a btn_press strobe.
- btn_level is glitch-free: it changes only on FSM acceptance.

Test Plan:
- Bench defaults: STABLE_COUNT=4, 20 ns clk period; reset=1 for 2 edges, btn_in=0.
- Reset -> btn_level=0, btn_press=0, btn_release=0 from the first reset edge; held 0 for 10 further cycles with btn_in=0.
- Clean press: btn_in 0->1 before edge k, held 20 cycles -> btn_level=1 from edge k+5; btn_press=1 only in that cycle; btn_release=0 throughout.
- Bounce rejection: after a clean low, btn_in pattern 1,1,0,1,1,1,0 (one value per cycle), then 0 -> btn_level stays 0, no strobe, state returns to IDLE_LOW.
- Bounce then settle: btn_in 1,0,1 then held 1 -> btn_level rises exactly STABLE_COUNT+2 edges after the final 0->1; exactly one btn_press.
- Release: from btn_level=1, btn_in 1->0 held -> btn_level=0 after STABLE_COUNT+2 edges; btn_release=1 for one cycle; btn_press=0.
- Reset mid-operation: assert reset during WAIT_HIGH with btn_in=1 held; release reset -> all outputs 0 while reset is high; btn_press fires STABLE_COUNT+2 edges after reset deasserts.

Source files
------------

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stability-counter FSM for a bouncing pin.
// Produces a clean level and one-cycle press/release strobes.
module button_debounce #(
    parameter int STABLE_COUNT = 1000000,
    parameter int CNT_WIDTH    = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam longint CNT_MAX = (64'sd1 <<< CNT_WIDTH) - 64'sd1;

    // Reject counter settings the counter cannot reach or that disable filtering.
    if (longint'(STABLE_COUNT) < 64'sd2
        || longint'(STABLE_COUNT) > CNT_MAX) begin : g_bad_count
        $error("button_debounce: STABLE_COUNT out of range");
    end

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(STABLE_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] count, count_nxt;
    logic                 sync0, sync1;
    logic                 level_nxt, press_nxt, release_nxt;

    // Bring the asynchronous pin into the clk domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= btn_in;
            sync1 <= sync0;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE_LOW;
            count       <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            btn_level   <= level_nxt;
            btn_press   <= press_nxt;
            btn_release <= release_nxt;
        end
    end

    // Qualify a new level only after an unbroken run of matching samples.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (sync1) begin
                    state_nxt = WAIT_HIGH;
                    count_nxt = ONE;
                end else begin
                    count_nxt = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync1) begin
                    state_nxt = IDLE_LOW;
                    count_nxt = '0;
                end else if (count == LAST) begin
                    state_nxt = IDLE_HIGH;
                    count_nxt = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    count_nxt = count + ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync1) begin
                    state_nxt = WAIT_LOW;
                    count_nxt = ONE;
                end else begin
                    count_nxt = '0;
                end
            end
            WAIT_LOW: begin
                if (sync1) begin
                    state_nxt = IDLE_HIGH;
                    count_nxt = '0;
                end else if (count == LAST) begin
                    state_nxt   = IDLE_LOW;
                    count_nxt   = '0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    count_nxt = count + ONE;
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                count_nxt = '0;
            end
        endcase
    end

endmodule
